// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, 2-5 cycles per instruction plus memory wait states.
// Backpressure: FETCH stalls on imem_ready and MEM stalls on dmem_ready. TRAP is left only through reset.
module multicycle_control #(
  parameter logic [10:0] ADD_OP  = 11'h458,
  parameter logic [10:0] SUB_OP  = 11'h658,
  parameter logic [10:0] AND_OP  = 11'h450,
  parameter logic [10:0] ORR_OP  = 11'h550,
  parameter logic [10:0] LDUR_OP = 11'h7C2,
  parameter logic [10:0] STUR_OP = 11'h7C0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg2_loc,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        instr_done,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_R    = 3'd1,
    CL_LD   = 3'd2,
    CL_ST   = 3'd3,
    CL_CBZ  = 3'd4,
    CL_B    = 3'd5
  } iclass_t;

  state_t  state_q, state_d;
  iclass_t class_q, class_d, dec_class;
  logic    illegal_q, illegal_d;

  logic       imem_req_c, ir_write_c, pc_write_c, pc_src_c;
  logic       reg2_loc_c, alu_src_c, mem_read_c, mem_write_c;
  logic       mem_to_reg_c, reg_write_c, instr_done_c;
  logic [1:0] alu_op_c;

  always_comb begin
    dec_class = CL_NONE;
    if (opcode == ADD_OP || opcode == SUB_OP || opcode == AND_OP || opcode == ORR_OP) begin
      dec_class = CL_R;
    end else if (opcode == LDUR_OP) begin
      dec_class = CL_LD;
    end else if (opcode == STUR_OP) begin
      dec_class = CL_ST;
    end else if (opcode[10:3] == 8'hB4) begin
      dec_class = CL_CBZ;
    end else if (opcode[10:5] == 6'h05) begin
      dec_class = CL_B;
    end
  end

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    imem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    reg2_loc_c   = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = 2'b00;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    instr_done_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (en) begin
          imem_req_c = 1'b1;
          if (imem_ready) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            state_d    = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        class_d = dec_class;
        case (dec_class)
          CL_R, CL_LD, CL_ST, CL_CBZ: state_d = S_EXEC;
          CL_B: begin
            pc_write_c   = 1'b1;
            pc_src_c     = 1'b1;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_EXEC: begin
        case (class_q)
          CL_R: begin
            alu_op_c = 2'b10;
            state_d  = S_WB;
          end
          CL_LD: begin
            alu_src_c = 1'b1;
            state_d   = S_MEM;
          end
          CL_ST: begin
            alu_src_c  = 1'b1;
            reg2_loc_c = 1'b1;
            state_d    = S_MEM;
          end
          CL_CBZ: begin
            // Branch target is already in the PC source mux; zero decides whether it is taken.
            alu_op_c     = 2'b01;
            reg2_loc_c   = 1'b1;
            pc_src_c     = 1'b1;
            pc_write_c   = zero;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        case (class_q)
          CL_LD: begin
            mem_read_c = 1'b1;
            alu_src_c  = 1'b1;
            if (dmem_ready) state_d = S_WB;
          end
          CL_ST: begin
            mem_write_c = 1'b1;
            reg2_loc_c  = 1'b1;
            alu_src_c   = 1'b1;
            if (dmem_ready) begin
              instr_done_c = 1'b1;
              state_d      = S_FETCH;
            end
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (class_q == CL_LD);
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      class_q   <= CL_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset forces the strobes low immediately, even though FETCH decode depends on live inputs.
  assign imem_req   = imem_req_c   & ~reset;
  assign ir_write   = ir_write_c   & ~reset;
  assign pc_write   = pc_write_c   & ~reset;
  assign pc_src     = pc_src_c     & ~reset;
  assign reg2_loc   = reg2_loc_c   & ~reset;
  assign alu_src    = alu_src_c    & ~reset;
  assign alu_op     = alu_op_c     & {2{~reset}};
  assign mem_read   = mem_read_c   & ~reset;
  assign mem_write  = mem_write_c  & ~reset;
  assign mem_to_reg = mem_to_reg_c & ~reset;
  assign reg_write  = reg_write_c  & ~reset;
  assign instr_done = instr_done_c & ~reset;
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencing controller for the LEGv8 datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control signals (reg2_loc, alu_src, alu_op, mem_read/write, mem_to_reg, reg_write) per state.
- Handshakes with instruction and data memory, which have variable wait states.
- Replaces the single-cycle combinational decode so that one ALU and one memory port are shared across cycles.

Parameters:
- ADD_OP, 11'h458, opcode for ADD
- SUB_OP, 11'h658, opcode for SUB
- AND_OP, 11'h450, opcode for AND
- ORR_OP, 11'h550, opcode for ORR
- LDUR_OP, 11'h7C2, opcode for LDUR
- STUR_OP, 11'h7C0, opcode for STUR

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- en  in  1  run enable, sampled only in FETCH
- opcode  in  11  instruction[31:21] from the instruction register
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load the instruction register
- pc_write  out  1  update the PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- reg2_loc  out  1  0 = Rm, 1 = Rt as read register 2
- alu_src  out  1  0 = register, 1 = sign-extended immediate
- alu_op  out  2  00 add, 01 pass/zero-test, 10 R-type funct
- mem_read  out  1  data memory read strobe
- mem_write  out  1  data memory write strobe
- mem_to_reg  out  1  writeback source is memory
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on instruction retire
- illegal  out  1  sticky undefined-opcode flag
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7

Behaviour:
- Reset (asynchronous, immediate, including mid-instruction): state=FETCH, internal class register cleared, illegal=0. All outputs are 0 while reset is asserted and in the first FETCH cycle until en=1.
- Outputs are decoded from state and the latched class. pc_write, ir_write and instr_done may also depend combinationally on imem_ready, dmem_ready and zero as listed below. Every output not named for a state is 0.
- FETCH:
  - en=0: remain in FETCH, imem_req=0.
  - en=1: imem_req=1. Hold until imem_ready=1, then in that same cycle assert ir_write=1, pc_write=1, pc_src=0, and go to DECODE.
- DECODE: classify opcode and latch the class.
  - R (ADD/SUB/AND/ORR), LD, ST, CBZ (opcode[10:3]=8'hB4): go to EXEC.
  - B (opcode[10:5]=6'h05): pc_write=1, pc_src=1, instr_done=1, go to FETCH.
  - Any other opcode: go to TRAP.
- EXEC:
  - R: alu_op=10, alu_src=0, reg2_loc=0; go to WB.
  - LD: alu_op=00, alu_src=1; go to MEM.
  - ST: alu_op=00, alu_src=1, reg2_loc=1; go to MEM.
  - CBZ: alu_op=01, alu_src=0, reg2_loc=1, pc_src=1, pc_write=zero, instr_done=1; go to FETCH.
- MEM:
  - LD: mem_read=1, alu_op=00, alu_src=1, held until dmem_ready=1; then go to WB.
  - ST: mem_write=1, reg2_loc=1, alu_op=00, alu_src=1, held until dmem_ready=1. In the ready cycle instr_done=1; go to FETCH.
- WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LD, 0 for R; instr_done=1; go to FETCH.
- TRAP: illegal=1, all other outputs 0. Exit only via reset; en is ignored.
- en deasserted mid-instruction has no effect; the current instruction completes and the block then idles in FETCH.
- Latency with zero wait states (imem_ready/dmem_ready high), in cycles from FETCH to retire:
  - B: 2
  - CBZ: 3
  - R: 4
  - STUR: 4
  - LDUR: 5
- Each wait-state cycle adds 1 cycle.
- mem_read and mem_write are never asserted simultaneously. reg_write is never asserted outside WB.

Test Plan:
- Reset, then en=1 with ADD 11'h458 and both readies high: state sequence 0,1,2,4,0. alu_op=10 in EXEC. reg_write=1, mem_to_reg=0 in WB. instr_done high 1 cycle at cycle 4.
- LDUR 11'h7C2 with dmem_ready low for 2 cycles: MEM held 3 cycles with mem_read=1 and alu_src=1. WB has mem_to_reg=1, reg_write=1. Total 7 cycles.
- STUR 11'h7C0: reg2_loc=1 in EXEC and MEM. mem_write=1 until dmem_ready. reg_write stays 0. Retires in MEM after 4 cycles.
- CBZ 11'h5A7: with zero=1, pc_write=1 and pc_src=1 in EXEC; with zero=0, pc_write=0. Both retire in 3 cycles.
- B 11'h0AF: retires in DECODE with pc_write=1, pc_src=1. Opcode 11'h765: state=7, illegal=1, held for 10 cycles with en=1, cleared only by reset.
- Assert reset mid-MEM of LDUR with imem_ready low: state=0 and all outputs 0 immediately, asynchronous to clk. With en=0, stays in FETCH with imem_req=0.
